// File: rtl/spi_accel_responder.sv
// spi_accel_responder
// SPI-slave stand-in for an ADXL362-style accelerometer (SPI mode 0).
// sclk, cs_n and mosi are oversampled on clk; sclk is never used as a clock.
// Commands: 0x0B = read burst, 0x0A = write burst, anything else is ignored.
// Write bursts reach only the 16-byte scratch RAM at 0x20..0x2F.
//
// Ports:
//   clk, resetn              system clock, synchronous active-low reset
//   sclk, cs_n, mosi         asynchronous SPI inputs from the master
//   miso, miso_oe            slave data out and read-phase output enable
//   x_data, y_data, z_data   live axis samples, snapshotted per read burst
//   busy                     high while a transaction is in progress
//   cmd_err                  one-clk pulse on an unknown command byte
//
// state  | meaning
// IDLE   | waiting for cs_n to fall
// CMD    | shifting in the command byte
// ADDR   | shifting in the address byte
// RD     | read data phase, driving miso
// WR     | write data phase, storing complete bytes
// IGNORE | bad command, discard all bits until cs_n rises
module spi_accel_responder #(
   parameter logic [7:0] DEVID_AD  = 8'hAD,
   parameter logic [7:0] DEVID_MST = 8'h1D,
   parameter logic [7:0] PARTID    = 8'hF2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       sclk,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] x_data,
   input  logic [7:0] y_data,
   input  logic [7:0] z_data,
   output logic       busy,
   output logic       cmd_err
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, RD, WR, IGNORE} state_t;

   state_t     state;
   logic [2:0] sclk_sr;
   logic [2:0] cs_sr;
   logic [1:0] mosi_sr;
   logic [2:0] bit_cnt;
   logic [7:0] shift_in;
   logic [7:0] tx;
   logic [7:0] addr;
   logic       rd_mode;
   logic [7:0] shadow_x, shadow_y, shadow_z;
   logic [7:0] ram [16];

   logic       sclk_rise, sclk_fall, cs_rise, cs_fall, byte_done;
   logic [7:0] byte_in;
   logic [7:0] addr_next;
   logic [7:0] load_val;
   logic [7:0] next_val;

   function automatic logic [7:0] reg_read(input logic [7:0] a,
                                           input logic [7:0] sx,
                                           input logic [7:0] sy,
                                           input logic [7:0] sz,
                                           input logic [7:0] ram_word);
      logic [7:0] v;
      v = 8'h00;
      if (a[7:4] == 4'h2) v = ram_word;
      else begin
         case (a)
            8'h00:   v = DEVID_AD;
            8'h01:   v = DEVID_MST;
            8'h02:   v = PARTID;
            8'h08:   v = sx;
            8'h09:   v = sy;
            8'h0A:   v = sz;
            default: v = 8'h00;
         endcase
      end
      return v;
   endfunction

   // Stage [0] and [1] are the synchronizer, [2] is the edge register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sclk_sr <= 3'b000;
         cs_sr   <= 3'b111;
         mosi_sr <= 2'b00;
      end else begin
         sclk_sr <= {sclk_sr[1:0], sclk};
         cs_sr   <= {cs_sr[1:0], cs_n};
         mosi_sr <= {mosi_sr[0], mosi};
      end
   end

   assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
   assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
   assign cs_rise   = cs_sr[1] & ~cs_sr[2];
   assign cs_fall   = ~cs_sr[1] & cs_sr[2];
   assign byte_in   = {shift_in[6:0], mosi_sr[1]};
   assign byte_done = sclk_rise && (bit_cnt == 3'd7);
   assign addr_next = addr + 8'd1;
   assign busy      = (state != IDLE);

   // The first read byte must see the samples being captured this cycle,
   // so it takes the live inputs; later burst bytes use the shadows.
   assign load_val = reg_read(byte_in, x_data, y_data, z_data, ram[byte_in[3:0]]);
   assign next_val = reg_read(addr_next, shadow_x, shadow_y, shadow_z, ram[addr_next[3:0]]);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         bit_cnt  <= 3'd0;
         shift_in <= 8'h00;
         tx       <= 8'h00;
         addr     <= 8'h00;
         rd_mode  <= 1'b0;
         shadow_x <= 8'h00;
         shadow_y <= 8'h00;
         shadow_z <= 8'h00;
         miso     <= 1'b0;
         miso_oe  <= 1'b0;
         cmd_err  <= 1'b0;
         for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      end else begin
         cmd_err <= 1'b0;
         if (cs_rise) begin
            // Wins over a coincident sclk edge; any partial byte is dropped.
            state   <= IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     bit_cnt <= 3'd0;
                     state   <= CMD;
                  end
               end
               CMD: begin
                  if (sclk_rise) begin
                     shift_in <= byte_in;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (byte_done) begin
                        case (byte_in)
                           8'h0B: begin rd_mode <= 1'b1; state <= ADDR; end
                           8'h0A: begin rd_mode <= 1'b0; state <= ADDR; end
                           default: begin cmd_err <= 1'b1; state <= IGNORE; end
                        endcase
                     end
                  end
               end
               ADDR: begin
                  if (sclk_rise) begin
                     shift_in <= byte_in;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (byte_done) begin
                        addr <= byte_in;
                        if (rd_mode) begin
                           shadow_x <= x_data;
                           shadow_y <= y_data;
                           shadow_z <= z_data;
                           tx       <= load_val;
                           miso     <= load_val[7];
                           miso_oe  <= 1'b1;
                           state    <= RD;
                        end else begin
                           state <= WR;
                        end
                     end
                  end
               end
               RD: begin
                  if (sclk_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (byte_done) begin
                        addr <= addr_next;
                        tx   <= next_val;
                        miso <= next_val[7];
                     end
                  end else if (sclk_fall && (bit_cnt != 3'd0)) begin
                     // The fall right after a byte boundary keeps the MSB
                     // that was just loaded; it has not been sampled yet.
                     tx   <= {tx[6:0], 1'b0};
                     miso <= tx[6];
                  end
               end
               WR: begin
                  if (sclk_rise) begin
                     shift_in <= byte_in;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (byte_done) begin
                        if (addr[7:4] == 4'h2) ram[addr[3:0]] <= byte_in;
                        addr <= addr_next;
                     end
                  end
               end
               IGNORE: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/spi_accel_responder.md
# spi_accel_responder

Synthesizable SPI-slave model of the ADXL362-style accelerometer that the SoC's SPI master polls over MOSI/MISO/SCLK. It decodes the master's command/address/data byte stream and returns register contents, including X/Y/Z samples supplied on parallel inputs. It serves as the on-board stand-in for the sensor in system-level simulation and on FPGA when no physical accelerometer is attached. It is clocked by the system clock and oversamples SCLK. It never uses SCLK as a clock.

## Interface
Parameters:
- DEVID_AD, 8'hAD, value of register 0x00
- DEVID_MST, 8'h1D, value of register 0x01
- PARTID, 8'hF2, value of register 0x02

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- sclk  in  1  SPI clock from master (mode 0, idle low), asynchronous
- cs_n  in  1  chip select, active low, asynchronous
- mosi  in  1  master-out data, asynchronous
- miso  out  1  slave-out data
- miso_oe  out  1  high while a read data phase is in progress
- x_data / y_data / z_data  in  8 each  current axis samples
- busy  out  1  high while cs_n is low and a transaction is in progress
- cmd_err  out  1  one-clk pulse when an unknown command byte is received

## Operation
- sclk, cs_n, mosi each pass through a 2-FF synchronizer. Rise and fall events are detected from the 2nd and 3rd stages.
- The bit counter is 3 bits, MSB first. A byte completes on the 8th sclk rise.
- FSM states:
  - IDLE: waits for cs_n falling. Then clears the bit counter and goes to CMD.
  - CMD: shifts in the command byte.
    - 0x0B goes to ADDR with read set.
    - 0x0A goes to ADDR with write set.
    - Any other value pulses cmd_err and goes to IGNORE.
  - ADDR: shifts in the address into an 8-bit addr register.
    - For a read, on byte completion: snapshot x/y/z into shadow registers, load the tx shift register with reg[addr], drive its MSB on miso, assert miso_oe, and go to RD.
    - For a write, go to WR.
  - RD: on each sclk fall, shift the tx register and drive the next bit. On the 8th rise, addr <= addr+1 (wraps 0xFF to 0x00) and the tx register reloads with reg[new addr], MSB driven immediately. Burst reads continue indefinitely.
  - WR: on byte completion, write the byte to reg[addr] if addr is in 0x20..0x2F (ignored otherwise), then addr <= addr+1 (wraps).
  - IGNORE: discards all bits until cs_n rises.
- cs_n rising in any state returns the FSM to IDLE. It also clears miso_oe, sets miso to 0, and discards any partial byte (no partial write).
- Register map for reads:
  - 0x00 DEVID_AD, 0x01 DEVID_MST, 0x02 PARTID
  - 0x08 X shadow, 0x09 Y shadow, 0x0A Z shadow
  - 0x20..0x2F scratch RAM, 16×8
  - all other addresses read 0x00
- Shadow registers are updated only at read-address completion, so a burst returns a coherent X/Y/Z set.
- busy equals "FSM state is not IDLE".

## Timing
- Reset values: miso=0, miso_oe=0, busy=0, cmd_err=0, FSM in IDLE, addr=0, scratch RAM all 0x00, shadows 0x00.
- Reset wins over any sclk or cs_n event in the same cycle. Reset asserted mid-transaction aborts with no write.
- Input to event latency: 3 clk (2 sync stages plus 1 edge register). All actions occur on the clk edge where the event is registered.
- miso changes 1 clk after a registered sclk fall, or after the registered 8th rise for a byte boundary.
- Constraints on the master:
  - sclk high time and low time ≥ 4 clk each.
  - cs_n setup to the first sclk rise ≥ 4 clk.
  - cs_n hold after the last sclk fall ≥ 4 clk.
- Simultaneous cs_n rise and sclk rise registered in the same cycle: cs_n takes precedence and the bit is discarded.
- cmd_err is high for exactly one clk, in the cycle after the 8th command bit is registered.

## Test plan
- Identity burst: resetn high; master sends cs_n low, 0x0B, 0x00, then reads 3 bytes. Required: miso returns 0xAD, 0x1D, 0xF2; miso_oe high through the data phase; busy drops 3 clk after cs_n rises.
- Axis read: x/y/z = 0x12/0x34/0x56; read burst from 0x08. Change x_data to 0xFF after the address byte. Required: returns 0x12, 0x34, 0x56 (snapshot holds).
- Scratch write/read: write 0x0A, 0x2F, data 0xA5, 0x3C. Then read from 0x2F for 2 bytes. Required: 0x2F reads 0xA5; address 0x30 reads 0x00 (unmapped, and the 0x3C write was ignored).
- Address wrap: read from 0xFF for 2 bytes. Required: 0x00 then 0xAD.
- Bad command and abort:
  - Command 0x55 gives a single-clk cmd_err pulse, miso stays 0, and the next transaction works normally.
  - Separately, a write to 0x20 with cs_n raised after 5 data bits leaves 0x20 at 0x00.
- Reset mid-read: assert resetn low during the 3rd data bit. Required: next clk has miso=0, miso_oe=0, busy=0, and the scratch RAM is cleared.
